// File: rtl/lbp_host_mem_if.sv
// Bus between the system/LBP engine side and the host image/result memory.
// The memory block takes the slave view; the stream source, engine and
// result sink together take the master view.
interface lbp_host_mem_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    // image load stream
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    // engine gray-pixel reads
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_req;
    logic              gray_ready;
    logic [DATA_W-1:0] gray_data;
    // engine LBP result writes
    logic [ADDR_W-1:0] lbp_addr;
    logic              lbp_valid;
    logic [DATA_W-1:0] lbp_data;
    logic              finish;
    // result dump stream
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    // status
    logic [ADDR_W-1:0] lbp_cnt;
    logic              done;

    modport slave (
        input  load_valid, load_data, gray_addr, gray_req,
               lbp_addr, lbp_valid, lbp_data, finish, dump_ready,
        output load_ready, gray_ready, gray_data, dump_valid,
               dump_addr, dump_data, dump_last, lbp_cnt, done
    );

    modport master (
        output load_valid, load_data, gray_addr, gray_req,
               lbp_addr, lbp_valid, lbp_data, finish, dump_ready,
        input  load_ready, gray_ready, gray_data, dump_valid,
               dump_addr, dump_data, dump_last, lbp_cnt, done
    );
endinterface

// File: rtl/lbp_host_mem.sv
// Host-side image/result memory for the LBP engine.
// Frame flow: LOAD (stream the gray image in) -> SERVE (engine reads pixels
// and writes LBP codes) -> DUMP (stream results out, border forced to 0)
// -> DONE (one-cycle completion pulse) -> LOAD.
module lbp_host_mem #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int IMG_W  = 128
) (
    input  logic         clk,
    input  logic         reset,
    lbp_host_mem_if.slave bus
);
    localparam int              COL_W     = ADDR_W / 2;
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [COL_W-1:0]  EDGE_HI   = COL_W'(IMG_W - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SERVE,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] ld_ptr;
    logic [ADDR_W-1:0] dp_ptr;
    logic [ADDR_W-1:0] lbp_cnt;

    logic [DATA_W-1:0] gray_mem [DEPTH];
    logic [DATA_W-1:0] lbp_mem  [DEPTH];

    logic load_ready;
    logic gray_ready;
    logic dump_valid;
    logic done;
    logic load_beat;
    logic dump_beat;
    logic lbp_write;

    // gray_req is purely advisory: reads are never stalled
    logic unused_gray_req;
    assign unused_gray_req = bus.gray_req;

    // Result-count increment that sticks at the top code instead of wrapping.
    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (v == LAST_ADDR) ? v : v + 1'b1;
    endfunction

    // Border pixels (first/last row or column) have no full 3x3 neighbourhood.
    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        logic [COL_W-1:0] row;
        logic [COL_W-1:0] col;
        row = a[ADDR_W-1:COL_W];
        col = a[COL_W-1:0];
        return (row == '0) || (row == EDGE_HI) || (col == '0) || (col == EDGE_HI);
    endfunction

    assign load_beat = bus.load_valid & load_ready;
    assign dump_beat = dump_valid & bus.dump_ready;
    assign lbp_write = (state == ST_SERVE) & bus.lbp_valid;

    // State register; reset returns to LOAD immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        gray_ready = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        case (state)
            ST_LOAD: begin
                load_ready = 1'b1;
                if (bus.load_valid && (ld_ptr == LAST_ADDR)) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                gray_ready = 1'b1;
                if (bus.finish) begin
                    state_next = ST_DUMP;
                end
            end
            ST_DUMP: begin
                dump_valid = 1'b1;
                if (bus.dump_ready && (dp_ptr == LAST_ADDR)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_LOAD;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // Load and dump pointers advance one per accepted beat and wrap to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_ptr <= '0;
            dp_ptr <= '0;
        end else begin
            if (load_beat) begin
                ld_ptr <= ld_ptr + 1'b1;
            end
            if (dump_beat) begin
                dp_ptr <= dp_ptr + 1'b1;
            end
        end
    end

    // Count captured LBP writes for this frame; cleared on the way back to LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lbp_cnt <= '0;
        end else if (state == ST_DONE) begin
            lbp_cnt <= '0;
        end else if (lbp_write) begin
            lbp_cnt <= sat_inc(lbp_cnt);
        end
    end

    // Image store: written only by load beats, never cleared.
    always_ff @(posedge clk) begin
        if (load_beat) begin
            gray_mem[ld_ptr] <= bus.load_data;
        end
    end

    // Result store: written only by engine writes during SERVE, never cleared.
    always_ff @(posedge clk) begin
        if (lbp_write) begin
            lbp_mem[bus.lbp_addr] <= bus.lbp_data;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.gray_ready = gray_ready;
    assign bus.gray_data  = gray_mem[bus.gray_addr];
    assign bus.dump_valid = dump_valid;
    assign bus.dump_addr  = dp_ptr;
    assign bus.dump_data  = is_border(dp_ptr) ? '0 : lbp_mem[dp_ptr];
    assign bus.dump_last  = dump_valid & (dp_ptr == LAST_ADDR);
    assign bus.lbp_cnt    = lbp_cnt;
    assign bus.done       = done;

endmodule
